// File: rtl/conf_add_budget_seq_if.sv
// Operand-pair stream into conf_add_budget_seq: valid/ready handshake carrying one a/b pair per beat.
interface conf_add_budget_seq_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  modport master (output in_valid, in_a, in_b, input in_ready);
  modport slave  (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/conf_add_budget_seq.sv
// Job sequencer around a combinational accurate/approximate adder: spends an approximate budget first,
// then goes accurate, and accumulates the job sum. Define CONF_ADD_SEQ_SAT_EN for a saturating accumulator plus sat_flag.
module conf_add_budget_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic [CNT_W-1:0]     apx_budget,
  input  logic                 force_acc,
  conf_add_budget_seq_if.slave in_bus,
  output logic [DATA_W-1:0]    add_a,
  output logic [DATA_W-1:0]    add_b,
  output logic                 add_acc_sel,
  input  logic [DATA_W:0]      add_d,
  output logic                 busy,
  output logic                 res_valid,
  output logic [ACC_W-1:0]     res_sum,
  output logic [CNT_W-1:0]     apx_used
`ifdef CONF_ADD_SEQ_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] budget_q;
  logic [CNT_W-1:0] issued;
  logic             s1_vld;

  logic             hs;
  logic             sel_next;
  logic [ACC_W-1:0] add_ext;
  logic [ACC_W-1:0] sum_next;

  assign in_bus.in_ready = (state == RUN) && (issued < len_q);
  assign hs              = in_bus.in_valid && in_bus.in_ready;
  assign busy            = (state != IDLE);

  // Once the budget is spent every op goes accurate; forced ops never consume budget.
  assign sel_next = force_acc || (apx_used >= budget_q);
  assign add_ext  = ACC_W'(add_d);

`ifdef CONF_ADD_SEQ_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           sat_hit;
  assign sum_wide = {1'b0, res_sum} + {1'b0, add_ext};
  assign sat_hit  = sum_wide[ACC_W];
  assign sum_next = sat_hit ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign sum_next = res_sum + add_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      budget_q    <= '0;
      issued      <= '0;
      s1_vld      <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_acc_sel <= 1'b0;
      res_valid   <= 1'b0;
      res_sum     <= '0;
      apx_used    <= '0;
`ifdef CONF_ADD_SEQ_SAT_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      s1_vld    <= 1'b0;

      // Stage 2: the adder output for last cycle's operands is folded in here.
      if (s1_vld) begin
        res_sum <= sum_next;
`ifdef CONF_ADD_SEQ_SAT_EN
        if (sat_hit) sat_flag <= 1'b1;
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            budget_q <= apx_budget;
            res_sum  <= '0;
            apx_used <= '0;
            issued   <= '0;
            s1_vld   <= 1'b0;
`ifdef CONF_ADD_SEQ_SAT_EN
            sat_flag <= 1'b0;
`endif
            if (len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (hs) begin
            add_a       <= in_bus.in_a;
            add_b       <= in_bus.in_b;
            add_acc_sel <= sel_next;
            if (!sel_next) apx_used <= apx_used + 1'b1;
            issued      <= issued + 1'b1;
            s1_vld      <= 1'b1;
          end
          // Last op is accumulating on this edge, so the sum is final right after it.
          if (s1_vld && (issued == len_q)) begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conf_add_budget_seq.md
Name: conf_add_budget_seq

Overview:
- Sequencer for the duplicated accurate/approximate 32-bit integer adder wrapper: takes a job of N operand pairs, streams them into the adder and drives its accuracy select per operation.
- Spends a programmable budget of approximate operations first, then switches to the accurate path.
- Accumulates the adder results into a job sum and reports it with a done pulse.
- The adder is combinational (no flops); this block provides the operand and result registers around it.

Parameters:
- DATA_W, 32, operand width presented to the adder.
- CNT_W, 16, width of the length, budget and counters.
- ACC_W, 48, accumulator width; adder result (DATA_W+1) is zero-extended into it.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  job start pulse; sampled only in IDLE.
- len  input  CNT_W  number of operand pairs in the job; latched on start.
- apx_budget  input  CNT_W  number of approximate operations allowed; latched on start.
- force_acc  input  1  level; while 1, every issued op uses the accurate path and the op is not charged to the budget.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  operand pair accepted when in_valid & in_ready.
- in_a  input  DATA_W  operand a.
- in_b  input  DATA_W  operand b.
- add_a  output  DATA_W  registered operand to adder.
- add_b  output  DATA_W  registered operand to adder.
- add_acc_sel  output  1  registered select; 1 = accurate path, 0 = approximate path.
- add_d  input  DATA_W+1  combinational adder result for add_a/add_b.
- busy  output  1  high in RUN and DONE.
- res_valid  output  1  one-cycle pulse; res_sum valid.
- res_sum  output  ACC_W  job sum; holds until next start.
- apx_used  output  CNT_W  approximate ops issued in current/last job.

Behaviour:
Reset values:
- All outputs and internal registers are 0; state is IDLE.
- rst asserted mid-job aborts the job immediately: no res_valid, sum cleared.

States are IDLE, RUN, DONE.

IDLE:
- in_ready=0.
- On start: latch len and apx_budget; clear res_sum, apx_used, the issued counter and s1_vld.
- If len==0, go to DONE; otherwise go to RUN.

RUN:
- in_ready = (issued < len).
- On handshake: load add_a/add_b from in_a/in_b, set s1_vld=1, issued++.
- add_acc_sel = force_acc | (apx_used >= budget). If the resulting select is 0, apx_used++.
- With no handshake, s1_vld=0; add_a/add_b/add_acc_sel hold their values.

Stage 2:
- Each cycle with s1_vld=1, res_sum += zero-extended add_d.
- Accumulation wraps modulo 2^ACC_W.

Completion:
- When issued==len and the final op is accumulating (s1_vld=1, no op outstanding), go to DONE at that edge.

DONE:
- res_valid=1 for exactly one cycle, then go to IDLE.

Latency and throughput:
- Handshake at edge k: operands reach the adder after edge k, the result is accumulated at edge k+1, and res_valid is high in the cycle after edge k+1 (for the last op).
- Throughput is one op per cycle with in_valid held high.

Boundary conditions:
- apx_budget=0: all ops accurate.
- apx_budget>=len: all ops approximate (unless force_acc).
- start while busy: ignored.
- in_valid without start (IDLE): not accepted.
- force_acc toggling mid-job: takes effect on the next issued op.
- Bubbles (in_valid=0) stall issue; they do not affect the sum or the counters.

Optional Feature:
- Macro CONF_ADD_SEQ_SAT_EN.
- Defined:
  - Accumulation saturates at 2^ACC_W-1 instead of wrapping.
  - Adds output sat_flag (1 bit), set on the first saturating accumulate and cleared on start and reset.
- Undefined: wrap modulo 2^ACC_W; no sat_flag port.

Test Plan:
- Bench adder model: accurate = a+b; approximate = a+b with low 8 bits of each operand zeroed.
- Test 1: len=4, budget=2, force_acc=0, pairs (0x100,0x1FF),(0x300,0x401),(5,6),(7,8), in_valid continuous.
  - add_acc_sel sequence 0,0,1,1.
  - res_sum = 0x200+0x700+11+15 = 0x91A.
  - apx_used=2.
  - res_valid 1 cycle after last accumulate, 6 cycles after start.
- Test 2: len=3, budget=0, pairs (1,2),(3,4),(0xFFFFFFFF,1) -> all acc_sel=1; res_sum=0x10000000A; apx_used=0.
- Test 3: len=0, start -> res_valid in the cycle after start, res_sum=0, no in_ready.
- Test 4: len=4, budget=4, force_acc=1 on 3rd op only, in_valid with 2-cycle bubbles -> acc_sel 0,0,1,0; apx_used=3; sum unaffected by bubbles.
- Test 5: rst pulsed after 2 of 4 ops -> all outputs 0, no res_valid. A new start with len=1, (10,20) -> res_sum=30.
- Test 6 (CONF_ADD_SEQ_SAT_EN): ACC_W=33, len=3, budget=0, pairs (0xFFFFFFFF,0xFFFFFFFF)x3 -> res_sum=0x1FFFFFFFF, sat_flag=1. Without the macro, the same stimulus wraps to 0x1FFFFFFFA.
